// File: rtl/mpy_div16_pkg.sv
// Shared constants, op codes and FSM state encoding for the iterative 16-bit multiply/divide unit.
package mpy_div16_pkg;

  localparam int W = 16;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mpy_div16_if.sv
// Request/result bundle between the register file (master) and the multiply/divide unit (slave).
interface mpy_div16_if;
  import mpy_div16_pkg::*;

  logic         start;
  logic         op;
  logic [W-1:0] S;
  logic [W-1:0] T;
  logic         busy;
  logic         done;
  logic [W-1:0] Y_hi;
  logic [W-1:0] Y_lo;
  logic         div0;

  modport master (output start, op, S, T, input busy, done, Y_hi, Y_lo, div0);
  modport slave  (input start, op, S, T, output busy, done, Y_hi, Y_lo, div0);

endinterface

// File: rtl/mpy_div16_md_step.sv
// One iteration of shift-add multiply or restoring divide; purely combinational.
module mpy_div16_md_step
  import mpy_div16_pkg::*;
(
  input  logic         op,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] opnd,
  output logic [W-1:0] hi_nxt,
  output logic [W-1:0] lo_nxt
);

  logic [W:0] sum;
  logic [W:0] shl;
  logic [W:0] diff;

  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shl  = {hi, lo[W-1]};
    // remainder < divisor, so bit W of the 17-bit difference is a valid borrow flag
    diff = shl - {1'b0, opnd};
    if (op == OP_MUL) begin
      hi_nxt = sum[W:1];
      lo_nxt = {sum[0], lo[W-1:1]};
    end else if (!diff[W]) begin
      hi_nxt = diff[W-1:0];
      lo_nxt = {lo[W-2:0], 1'b1};
    end else begin
      hi_nxt = shl[W-1:0];
      lo_nxt = {lo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mpy_div16.sv
// Iterative 16x16 unsigned MUL / 16/16 DIV: 16-cycle latency (1 for divide-by-zero).
// Start is only accepted in IDLE or DONE; results hold until the next completion.
module mpy_div16
  import mpy_div16_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  mpy_div16_if.slave bus
);

  state_t       state;
  state_t       state_nxt;
  logic         op_r;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] opnd;
  logic [W-1:0] hi_nxt;
  logic [W-1:0] lo_nxt;
  logic [3:0]   cnt;
  logic         accept;
  logic         div_zero;
  logic         last;

  assign accept   = bus.start && ((state == IDLE) || (state == DONE));
  assign div_zero = (bus.op == OP_DIV) && (bus.T == '0);
  assign last     = (state == CALC) && (cnt == 4'd15);

  mpy_div16_md_step u_step (
    .op     (op_r),
    .hi     (hi),
    .lo     (lo),
    .opnd   (opnd),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = div_zero ? DONE : CALC;
        else        state_nxt = IDLE;
      end
      CALC:    if (cnt == 4'd15) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      CALC:    bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // MUL: hi=0, lo=multiplier, opnd=multiplicand. DIV: hi=remainder, lo=dividend, opnd=divisor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_r     <= OP_MUL;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      cnt      <= '0;
      bus.Y_hi <= '0;
      bus.Y_lo <= '0;
      bus.div0 <= 1'b0;
    end else if (accept) begin
      op_r     <= bus.op;
      hi       <= '0;
      lo       <= (bus.op == OP_DIV) ? bus.S : bus.T;
      opnd     <= (bus.op == OP_DIV) ? bus.T : bus.S;
      cnt      <= '0;
      bus.div0 <= div_zero;
      if (div_zero) begin
        bus.Y_hi <= bus.S;
        bus.Y_lo <= '1;
      end
    end else if (state == CALC) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt + 4'd1;
      if (last) begin
        bus.Y_hi <= hi_nxt;
        bus.Y_lo <= lo_nxt;
      end
    end
  end

endmodule
